// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with a runtime-loadable pattern,
// selectable overlap, an input valid qualifier and a saturating match counter.
module seq_detector_param #(
   parameter int                 PAT_LEN = 5,
   parameter logic [PAT_LEN-1:0] PATTERN = 5'b11101,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_seq,
   input  logic               overlap_en,
   input  logic               pattern_load,
   input  logic [PAT_LEN-1:0] pattern_in,
   input  logic               count_clear,
   output logic               seq_detected,
   output logic               armed,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [4:0] FILL_MAX = 5'(PAT_LEN - 1);

   logic [PAT_LEN-1:0] pat_q,  pat_d;
   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [4:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;
   logic [PAT_LEN-1:0] window;
   logic               match;

   // Candidate window: the stored history with the incoming bit as its newest bit.
   assign window = {hist_q, in_seq};
   assign match  = in_valid & ~pattern_load & ~rst & (fill_q == FILL_MAX) & (window == pat_q);

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;

      if (pattern_load) begin
         pat_d  = pattern_in;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = window[PAT_LEN-2:0];
         if (match && !overlap_en) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 5'd1;
         end
      end

      // Clear beats a simultaneous match; the counter sticks at all-ones.
      if (count_clear) begin
         cnt_d = '0;
      end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q  <= PATTERN;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all of them update together.
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
      end
   end

   assign seq_detected = match;
   assign armed        = (fill_q == FILL_MAX);
   assign match_count  = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: one default instance and one with a
// 3-bit counter share stimulus; expected strobes are queued when a bit is driven.
module tb_seq_detector_param;

   localparam int               PAT_LEN = 5;
   localparam logic [PAT_LEN-1:0] DEF_PAT = 5'b11101;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_seq, overlap_en, pattern_load, count_clear;
   logic [PAT_LEN-1:0] pattern_in;
   logic               seq8, armed8, seq3, armed3;
   logic [7:0]         cnt8;
   logic [2:0]         cnt3;

   int n_checks = 0;
   int n_errors = 0;
   int n_strobes;

   // Reference model state: recently accepted bits (oldest first), pattern, counts.
   logic               m_bits[$];
   logic [PAT_LEN-1:0] m_pat;
   int                 m_cnt8, m_cnt3;
   logic               sb[$];

   always #5 clk = ~clk;

   seq_detector_param u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
      .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
      .count_clear(count_clear), .seq_detected(seq8), .armed(armed8), .match_count(cnt8)
   );

   seq_detector_param #(.CNT_W(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
      .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
      .count_clear(count_clear), .seq_detected(seq3), .armed(armed3), .match_count(cnt3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_match(input logic b);
      logic [PAT_LEN-1:0] win;
      int                 base;
      if (m_bits.size() < PAT_LEN - 1) return 1'b0;
      base = m_bits.size() - (PAT_LEN - 1);
      for (int i = 0; i < PAT_LEN - 1; i++) win[PAT_LEN-1-i] = m_bits[base+i];
      win[0] = b;
      return win == m_pat;
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_pat  = DEF_PAT;
      m_cnt8 = 0;
      m_cnt3 = 0;
   endtask

   task automatic drive(input logic v, input logic b, input logic ovl, input logic clr,
                        input logic ld, input logic [PAT_LEN-1:0] pin);
      logic exp, e;
      @(negedge clk);
      in_valid = v; in_seq = b; overlap_en = ovl; count_clear = clr;
      pattern_load = ld; pattern_in = pin;
      exp = (v && !ld) ? model_match(b) : 1'b0;
      sb.push_back(exp);
      #1;
      e = sb.pop_front();
      check("strobe8", seq8, e);
      check("strobe3", seq3, e);
      if (seq8) n_strobes++;
      @(posedge clk);
      #1;
      in_valid = 1'b0; pattern_load = 1'b0; count_clear = 1'b0;
      if (ld) begin
         m_pat = pin;
         m_bits.delete();
      end else if (v) begin
         m_bits.push_back(b);
         if (exp && !ovl) m_bits.delete();
         else if (m_bits.size() > PAT_LEN - 1) void'(m_bits.pop_front());
      end
      if (clr) begin
         m_cnt8 = 0;
         m_cnt3 = 0;
      end else if (exp) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt3 < 7)   m_cnt3++;
      end
      check("armed8", armed8, m_bits.size() == PAT_LEN - 1);
      check("armed3", armed3, m_bits.size() == PAT_LEN - 1);
      check("count8", cnt8, m_cnt8);
      check("count3", cnt3, m_cnt3);
   endtask

   task automatic bit_in(input logic b, input logic ovl);
      drive(1'b1, b, ovl, 1'b0, 1'b0, '0);
   endtask

   task automatic stream(input logic [15:0] bits, input int n, input logic ovl);
      for (int i = n - 1; i >= 0; i--) bit_in(bits[i], ovl);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_strobe", seq8, 1'b0);
      check("rst_armed", armed8, 1'b0);
      check("rst_count8", cnt8, 0);
      check("rst_count3", cnt3, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_strobes = 0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_seq = 1'b0; overlap_en = 1'b1;
      pattern_load = 1'b0; pattern_in = '0; count_clear = 1'b0;
      model_reset();
      do_reset();

      // Test 1: default pattern, overlapping.
      stream(16'b11101, 5, 1'b1);
      check("t1_strobes", n_strobes, 1);
      check("t1_count", cnt8, 1);

      // Test 2: loaded 10101, overlapping then non-overlapping.
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10101);
      stream(16'b1010101, 7, 1'b1);
      check("t2_ovl_strobes", n_strobes, 2);
      check("t2_ovl_count", cnt8, 2);
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10101);
      stream(16'b1010101, 7, 1'b0);
      check("t2_novl_strobes", n_strobes, 1);
      check("t2_novl_count", cnt8, 1);

      // Test 3: gaps with in_seq=1 must neither pulse nor break the partial match.
      do_reset();
      stream(16'b11, 2, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      stream(16'b101, 3, 1'b1);
      check("t3_strobes", n_strobes, 1);

      // Test 4: nine non-overlapping frames saturate the 3-bit counter.
      do_reset();
      for (int f = 0; f < 9; f++) stream(16'b11101, 5, 1'b0);
      check("t4_strobes", n_strobes, 9);
      check("t4_count3_sat", cnt3, 7);
      check("t4_count8", cnt8, 9);
      stream(16'b1110, 4, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      check("t4_clear_strobes", n_strobes, 10);
      check("t4_clear_count3", cnt3, 0);
      check("t4_clear_count8", cnt8, 0);

      // Test 5: asynchronous reset in mid-cycle loses the partial match.
      do_reset();
      stream(16'b1110, 4, 1'b1);
      #3;
      rst = 1'b1;
      in_valid = 1'b1; in_seq = 1'b1;
      #1;
      check("t5_rst_strobe", seq8, 1'b0);
      check("t5_rst_armed", armed8, 1'b0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      model_reset();
      n_strobes = 0;
      bit_in(1'b1, 1'b1);
      check("t5_no_detect", n_strobes, 0);
      check("t5_count", cnt8, 0);
      stream(16'b11101, 5, 1'b1);
      check("t5_detect", n_strobes, 1);

      // Test 6: pattern load discards its in_seq bit and clears the history.
      do_reset();
      stream(16'b1110, 4, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00011);
      check("t6_load_strobes", n_strobes, 0);
      check("t6_load_armed", armed8, 1'b0);
      stream(16'b00011, 5, 1'b1);
      check("t6_strobes", n_strobes, 1);
      check("t6_count", cnt8, 1);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
